// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: shared-bus SPI memory controller, mode 0, NUM_DEV chip selects.
// Ports: clk/reset; CPU side dev_sel, word_address, wdata, wmask, rd, wr, rdata,
// rbusy, wbusy; SPI side spi_clk, spi_cs_n, spi_mosi, spi_miso.
module spi_mem_ctrl #(
  parameter int NUM_DEV     = 2,
  parameter int ADDR_BYTES  = 3,
  parameter int CLK_DIV     = 1,
  parameter int WORD_ADDR_W = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DEV-1:0]     dev_sel,
  input  logic [WORD_ADDR_W-1:0] word_address,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wmask,
  input  logic                   rd,
  input  logic                   wr,
  output logic [31:0]            rdata,
  output logic                   rbusy,
  output logic                   wbusy,
  output logic                   spi_clk,
  output logic [NUM_DEV-1:0]     spi_cs_n,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int SH_W = 40 + AW;
  localparam int BW   = $clog2(SH_W);
  localparam int DW   = $clog2(2 * CLK_DIV) + 1;
  localparam int XW   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [XW-1:0]        dev_q, dev_d;
  logic                 op_wr_q, op_wr_d;
  logic [WORD_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           mask_q, mask_d;
  logic [SH_W-1:0]      sh_q, sh_d;
  logic [BW-1:0]        last_q, last_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        div_q, div_d;
  logic [31:0]          rx_q, rx_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rbusy_q, rbusy_d;
  logic                 wbusy_q, wbusy_d;
  logic                 sclk_q, sclk_d;
  logic [NUM_DEV-1:0]   cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;

  logic [XW-1:0]        sel_idx;
  logic [3:0]           run_src;
  logic [1:0]           run_s;
  logic [2:0]           run_k;
  logic [3:0]           run_left;
  logic                 accept;

  function automatic logic [1:0] run_start(input logic [3:0] m);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) s = 2'(i);
    return s;
  endfunction

  // Length of the contiguous run of set bits beginning at s.
  function automatic logic [2:0] run_len(input logic [3:0] m,
                                         input logic [1:0] s);
    logic [2:0] k;
    logic       stop;
    k    = 3'd0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(s) && !stop) begin
        if (m[i]) k = k + 3'd1;
        else      stop = 1'b1;
      end
    end
    return k;
  endfunction

  function automatic logic [3:0] run_bits(input logic [1:0] s,
                                          input logic [2:0] k);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(s) && i < int'(s) + int'(k)) r[i] = 1'b1;
    return r;
  endfunction

  // Whole frame left-aligned: command, address, then payload bytes
  // lowest first. Reads carry a zero payload.
  function automatic logic [SH_W-1:0] frame(
    input logic                   wr_op,
    input logic [WORD_ADDR_W-1:0] wa,
    input logic [1:0]             s,
    input logic [2:0]             k,
    input logic [31:0]            wd
  );
    logic [63:0] full;
    logic [31:0] dat;
    logic [7:0]  cmd;
    logic [7:0]  b [4];
    full = 64'({wa, s});
    dat  = 32'd0;
    for (int j = 0; j < 4; j++) b[j] = wd[8*j +: 8];
    if (wr_op) begin
      for (int i = 0; i < 4; i++)
        if (i < int'(k)) dat[31-8*i -: 8] = b[2'(int'(s) + i)];
    end
    cmd = wr_op ? 8'h02 : 8'h03;
    return {cmd, full[AW-1:0], dat};
  endfunction

  function automatic logic [BW-1:0] last_bit(input logic [2:0] k);
    return BW'(8 + AW + 8 * int'(k) - 1);
  endfunction

  function automatic logic [NUM_DEV-1:0] cs_for(input logic [XW-1:0] d);
    return ~(NUM_DEV'(1) << d);
  endfunction

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--)
      if (dev_sel[i]) sel_idx = XW'(i);
  end

  always_comb begin
    run_src  = (state_q == IDLE) ? wmask : mask_q;
    run_s    = run_start(run_src);
    run_k    = run_len(run_src, run_s);
    run_left = run_src & ~run_bits(run_s, run_k);
  end

  assign accept = (rd | wr) & (|dev_sel);

  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    sh_d    = sh_q;
    last_d  = last_q;
    idx_d   = idx_q;
    div_d   = div_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rbusy_d = rbusy_q;
    wbusy_d = wbusy_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dev_d   = sel_idx;
          op_wr_d = wr;
          addr_d  = word_address;
          wdata_d = wdata;
          mask_d  = wr ? run_left : 4'd0;
          sh_d    = frame(wr, word_address,
                          wr ? run_s : 2'd0,
                          wr ? run_k : 3'd4, wdata);
          last_d  = last_bit(wr ? run_k : 3'd4);
          mosi_d  = sh_d[SH_W-1];
          cs_n_d  = cs_for(sel_idx);
          sclk_d  = 1'b0;
          idx_d   = '0;
          div_d   = '0;
          rbusy_d = ~wr;
          wbusy_d = wr;
          state_d = CMD;
        end
      end

      CMD, ADDR, DATA: begin
        if (div_q != HALF_END) begin
          div_d = div_q + 1'b1;
        end else if (!sclk_q) begin
          div_d  = '0;
          sclk_d = 1'b1;
          if (state_q == DATA) rx_d = {rx_q[30:0], spi_miso};
        end else begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (idx_q == last_q) begin
            cs_n_d  = '1;
            mosi_d  = 1'b0;
            state_d = GAP;
          end else begin
            idx_d  = idx_q + 1'b1;
            sh_d   = {sh_q[SH_W-2:0], 1'b0};
            mosi_d = sh_q[SH_W-2];
            if (idx_d == BW'(8))
              state_d = ADDR;
            else if (idx_d == BW'(8 + AW))
              state_d = DATA;
          end
        end
      end

      GAP: begin
        if (div_q != GAP_END) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          // Remaining mask bits mean another write run on the same device.
          if (op_wr_q && (|mask_q)) begin
            mask_d  = run_left;
            sh_d    = frame(1'b1, addr_q, run_s, run_k, wdata_q);
            last_d  = last_bit(run_k);
            mosi_d  = sh_d[SH_W-1];
            cs_n_d  = cs_for(dev_q);
            idx_d   = '0;
            state_d = CMD;
          end else begin
            if (!op_wr_q)
              rdata_d = {rx_q[7:0], rx_q[15:8],
                         rx_q[23:16], rx_q[31:24]};
            rbusy_d = 1'b0;
            wbusy_d = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dev_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      sh_q    <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rbusy_q <= 1'b0;
      wbusy_q <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= '1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dev_q   <= dev_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
      wbusy_q <= wbusy_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign rdata    = rdata_q;
  assign rbusy    = rbusy_q;
  assign wbusy    = wbusy_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: directed vector bench for spi_mem_ctrl (default and slow/short-address builds).
// Ports: none; drives two DUT instances, each with an SPI slave model on its bus.
module tb_spi_mem_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] resp;

  // Default build
  logic [1:0]  a_dev;
  logic [19:0] a_wa;
  logic [31:0] a_wd;
  logic [3:0]  a_wm;
  logic        a_rd, a_wr;
  logic [31:0] a_rdata;
  logic        a_rbusy, a_wbusy, a_sclk, a_mosi;
  logic        a_miso = 1'b0;
  logic [1:0]  a_csn;

  spi_mem_ctrl dut (
    .clk(clk), .reset(reset), .dev_sel(a_dev), .word_address(a_wa),
    .wdata(a_wd), .wmask(a_wm), .rd(a_rd), .wr(a_wr), .rdata(a_rdata),
    .rbusy(a_rbusy), .wbusy(a_wbusy), .spi_clk(a_sclk),
    .spi_cs_n(a_csn), .spi_mosi(a_mosi), .spi_miso(a_miso)
  );

  // CLK_DIV=3, ADDR_BYTES=2 build
  logic [1:0]  b_dev;
  logic [19:0] b_wa;
  logic [31:0] b_wd;
  logic [3:0]  b_wm;
  logic        b_rd, b_wr;
  logic [31:0] b_rdata;
  logic        b_rbusy, b_wbusy, b_sclk, b_mosi;
  logic        b_miso = 1'b0;
  logic [1:0]  b_csn;

  spi_mem_ctrl #(
    .NUM_DEV(2), .ADDR_BYTES(2), .CLK_DIV(3), .WORD_ADDR_W(20)
  ) dut3 (
    .clk(clk), .reset(reset), .dev_sel(b_dev), .word_address(b_wa),
    .wdata(b_wd), .wmask(b_wm), .rd(b_rd), .wr(b_wr), .rdata(b_rdata),
    .rbusy(b_rbusy), .wbusy(b_wbusy), .spi_clk(b_sclk),
    .spi_cs_n(b_csn), .spi_mosi(b_mosi), .spi_miso(b_miso)
  );

  function automatic logic miso_bit(input int b, input int hdr);
    if (b >= hdr && b < hdr + 32) return resp[31 - (b - hdr)];
    return 1'b0;
  endfunction

  // Slave model / monitor A
  logic [7:0] a_bytes[$];
  int   a_frames = 0, a_gap = 0, a_bit = 0, a_viol = 0;
  int   a_cslow0 = 0, a_cslow1 = 0;
  logic [7:0] a_sh = 8'd0;
  logic a_pclk = 1'b0, a_pmosi = 1'b0, a_pidle = 1'b1;

  always @(negedge clk) begin
    if (!(&a_csn) && a_pidle) begin
      a_frames++;
      a_bit = 0;
    end
    a_pidle = &a_csn;
    if (!a_csn[0]) a_cslow0++;
    if (!a_csn[1]) a_cslow1++;
    if ((a_rbusy || a_wbusy) && (&a_csn)) a_gap++;
    if (a_sclk && !a_pclk) begin
      a_sh = {a_sh[6:0], a_mosi};
      a_bit++;
      if (a_bit % 8 == 0) a_bytes.push_back(a_sh);
    end
    if (a_sclk && a_pclk && a_mosi != a_pmosi) a_viol++;
    a_pclk  = a_sclk;
    a_pmosi = a_mosi;
    a_miso  = miso_bit(a_bit, 32);
  end

  // Slave model / monitor B
  logic [7:0] b_bytes[$];
  int   b_bit = 0, b_run = 0, b_hmin = 999, b_hmax = 0;
  logic [7:0] b_sh = 8'd0;
  logic b_pclk = 1'b0, b_pidle = 1'b1;

  always @(negedge clk) begin
    if (!(&b_csn) && b_pidle) b_bit = 0;
    b_pidle = &b_csn;
    if (b_sclk) begin
      b_run++;
    end else if (b_run > 0) begin
      if (b_run < b_hmin) b_hmin = b_run;
      if (b_run > b_hmax) b_hmax = b_run;
      b_run = 0;
    end
    if (b_sclk && !b_pclk) begin
      b_sh = {b_sh[6:0], b_mosi};
      b_bit++;
      if (b_bit % 8 == 0) b_bytes.push_back(b_sh);
    end
    b_pclk = b_sclk;
    b_miso = miso_bit(b_bit, 24);
  end

  task automatic check(input string nm, input int i,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  dev;
    logic [19:0] wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] resp;
    int          kind;
    int          busy;
    int          frames;
    int          gap;
    logic [1:0]  cs;
    int          nb;
    int          ncmp;
    logic [95:0] bytes;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [10];

  task automatic run_vec(input vec_t v, input int id);
    int b0, f0, g0, c0, c1, n;
    logic [7:0] eb;
    resp = v.resp;
    b0 = a_bytes.size();
    f0 = a_frames;
    g0 = a_gap;
    c0 = a_cslow0;
    c1 = a_cslow1;
    @(posedge clk); #1;
    a_rd = v.rd; a_wr = v.wr; a_dev = v.dev;
    a_wa = v.wa; a_wd = v.wd; a_wm = v.wm;
    @(posedge clk); #1;
    a_rd = 1'b0; a_wr = 1'b0; a_dev = 2'b00;
    a_wa = 20'd0; a_wd = 32'd0; a_wm = 4'd0;
    check("rbusy_rise", id, 64'(a_rbusy), 64'(v.kind == 1));
    check("wbusy_rise", id, 64'(a_wbusy), 64'(v.kind == 2));
    n = 0;
    while ((a_rbusy || a_wbusy) && n < 5000) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_cycles", id, 64'(n), 64'(v.busy));
    repeat (3) @(posedge clk);
    #1;
    check("frames", id, 64'(a_frames - f0), 64'(v.frames));
    check("cs_gap", id, 64'(a_gap - g0), 64'(v.gap));
    check("cs_used", id, {62'd0, a_cslow1 > c1, a_cslow0 > c0}, 64'(v.cs));
    check("mosi_nbytes", id, 64'(a_bytes.size() - b0), 64'(v.nb));
    for (int i = 0; i < v.ncmp; i++) begin
      eb = v.bytes[95 - 8*i -: 8];
      if (b0 + i < a_bytes.size())
        check("mosi_byte", id * 100 + i, 64'(a_bytes[b0 + i]), 64'(eb));
      else
        check("mosi_byte", id * 100 + i, 64'hdead, 64'(eb));
    end
    check("rdata", id, 64'(a_rdata), 64'(v.rdata));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vr;
    int n, b0;
    reset = 1'b1;
    a_rd = 0; a_wr = 0; a_dev = 0; a_wa = 0; a_wd = 0; a_wm = 0;
    b_rd = 0; b_wr = 0; b_dev = 0; b_wa = 0; b_wd = 0; b_wm = 0;
    resp = 32'h0;

    vt[0] = '{1'b1, 1'b0, 2'b01, 20'h10, 32'h0, 4'h0, 32'h11223344,
              1, 130, 1, 2, 2'b01, 8, 4,
              {32'h03000040, 64'h0}, 32'h44332211};
    vt[1] = '{1'b0, 1'b1, 2'b10, 20'h3, 32'hDEADBEEF, 4'hF, 32'h0,
              2, 130, 1, 2, 2'b10, 8, 8,
              {64'h0200000CEFBEADDE, 32'h0}, 32'h44332211};
    vt[2] = '{1'b0, 1'b1, 2'b10, 20'h3, 32'hDEADBEEF, 4'h6, 32'h0,
              2, 98, 1, 2, 2'b10, 6, 6,
              {48'h0200000DBEAD, 48'h0}, 32'h44332211};
    vt[3] = '{1'b0, 1'b1, 2'b10, 20'h3, 32'hDEADBEEF, 4'h9, 32'h0,
              2, 164, 2, 4, 2'b10, 10, 10,
              {80'h0200000CEF0200000FDE, 16'h0}, 32'h44332211};
    vt[4] = '{1'b1, 1'b0, 2'b00, 20'h10, 32'h0, 4'h0, 32'h11223344,
              0, 0, 0, 0, 2'b00, 0, 0,
              96'h0, 32'h44332211};
    vt[5] = '{1'b1, 1'b1, 2'b01, 20'h3, 32'hDEADBEEF, 4'hF, 32'h11223344,
              2, 130, 1, 2, 2'b01, 8, 8,
              {64'h0200000CEFBEADDE, 32'h0}, 32'h44332211};
    vt[6] = '{1'b1, 1'b0, 2'b11, 20'h1, 32'h0, 4'h0, 32'hA55A0FF0,
              1, 130, 1, 2, 2'b01, 8, 4,
              {32'h03000004, 64'h0}, 32'hF00F5AA5};
    vt[7] = '{1'b0, 1'b1, 2'b10, 20'hFFFFF, 32'hDEADBEEF, 4'h4, 32'h0,
              2, 82, 1, 2, 2'b10, 5, 5,
              {40'h023FFFFEAD, 56'h0}, 32'hF00F5AA5};
    vt[8] = '{1'b0, 1'b1, 2'b01, 20'h3, 32'hDEADBEEF, 4'h3, 32'h0,
              2, 98, 1, 2, 2'b01, 6, 6,
              {48'h0200000CEFBE, 48'h0}, 32'hF00F5AA5};
    vt[9] = '{1'b0, 1'b1, 2'b01, 20'h3, 32'hDEADBEEF, 4'hB, 32'h0,
              2, 180, 2, 4, 2'b01, 11, 11,
              {88'h0200000CEFBE0200000FDE, 8'h0}, 32'hF00F5AA5};

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 0, 64'(a_csn), 64'h3);
    check("rst_sclk", 0, 64'(a_sclk), 64'h0);
    check("rst_mosi", 0, 64'(a_mosi), 64'h0);
    check("rst_rdata", 0, 64'(a_rdata), 64'h0);
    check("rst_busy", 0, {62'd0, a_rbusy, a_wbusy}, 64'h0);
    check("rst_cs_n", 1, 64'(b_csn), 64'h3);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Reset in the middle of a read aborts it at once.
    resp = 32'h11223344;
    @(posedge clk); #1;
    a_rd = 1'b1; a_dev = 2'b01; a_wa = 20'h10;
    @(posedge clk); #1;
    a_rd = 1'b0; a_dev = 2'b00; a_wa = 20'h0;
    repeat (49) @(posedge clk);
    #1;
    check("mid_cs_active", 0, 64'(a_csn), 64'h2);
    reset = 1'b1;
    #1;
    check("abort_cs_n", 0, 64'(a_csn), 64'h3);
    check("abort_sclk", 0, 64'(a_sclk), 64'h0);
    check("abort_rbusy", 0, 64'(a_rbusy), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_rdata", 0, 64'(a_rdata), 64'h0);

    vr = vt[0];
    vr.resp  = 32'hCAFEF00D;
    vr.rdata = 32'h0DF0FECA;
    run_vec(vr, 10);

    // Slow build: CLK_DIV=3, two address bytes.
    resp = 32'h11223344;
    b0 = b_bytes.size();
    @(posedge clk); #1;
    b_rd = 1'b1; b_dev = 2'b01; b_wa = 20'h1;
    @(posedge clk); #1;
    b_rd = 1'b0; b_dev = 2'b00; b_wa = 20'h0;
    check("b_rbusy_rise", 0, 64'(b_rbusy), 64'h1);
    check("b_cs_n", 0, 64'(b_csn), 64'h2);
    n = 0;
    while (b_rbusy && n < 5000) begin
      n++;
      @(posedge clk); #1;
    end
    check("b_busy_cycles", 0, 64'(n), 64'd342);
    repeat (3) @(posedge clk);
    #1;
    check("b_nbytes", 0, 64'(b_bytes.size() - b0), 64'd7);
    if (b_bytes.size() >= b0 + 3) begin
      check("b_byte", 0, 64'(b_bytes[b0]), 64'h03);
      check("b_byte", 1, 64'(b_bytes[b0 + 1]), 64'h00);
      check("b_byte", 2, 64'(b_bytes[b0 + 2]), 64'h04);
    end else begin
      check("b_bytes_present", 0, 64'(b_bytes.size() - b0), 64'd3);
    end
    check("b_half_min", 0, 64'(b_hmin), 64'd3);
    check("b_half_max", 0, 64'(b_hmax), 64'd3);
    check("b_rdata", 0, 64'(b_rdata), 64'h44332211);

    check("mosi_stable_high", 0, 64'(a_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Parametrised, multi-device SPI memory controller for the FemtoRV32 SoC. It is the successor to the separate mapped SPI flash and SPI RAM readers/writers. One shared SPI bus (SCLK/MOSI/MISO) serves NUM_DEV one-hot chip selects. It adds a configurable clock divider, a configurable address byte count, and true byte-masked writes driven by the CPU's mem_wmask. It sits behind the address decoder and drives the CPU's mem_rbusy/mem_wbusy.

## Interface
Parameters:
- NUM_DEV, 2, number of SPI devices / chip selects (1..8)
- ADDR_BYTES, 3, SPI address bytes sent after the command (1..4)
- CLK_DIV, 1, SPI half-period in clk cycles (>=1)
- WORD_ADDR_W, 20, width of word_address

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dev_sel  in  NUM_DEV  one-hot device select, qualified by rd/wr
- word_address  in  WORD_ADDR_W  32-bit word address
- wdata  in  32  write data, little-endian bytes
- wmask  in  4  byte write enables
- rd  in  1  read strobe, single cycle
- wr  in  1  write strobe, single cycle (wmask must be nonzero)
- rdata  out  32  read data
- rbusy  out  1  read in progress
- wbusy  out  1  write in progress
- spi_clk  out  1  SPI clock, mode 0
- spi_cs_n  out  NUM_DEV  active-low chip selects
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

## Operation
- Reset: spi_clk=0, spi_cs_n=all ones, spi_mosi=0, rdata=0, rbusy=0, wbusy=0, FSM=IDLE. Reset is asynchronous, so asserting it mid-transaction aborts the transfer immediately.
- FSM states:
  - IDLE → CMD on an accepted request.
  - CMD (8 bits) → ADDR (8*ADDR_BYTES bits) → DATA.
  - DATA → GAP.
  - GAP → IDLE when done, or → CMD for the next write run.
- Accepting requests:
  - A request is accepted only in IDLE, and only if dev_sel is nonzero; otherwise it is ignored and busy stays 0.
  - If dev_sel is multi-hot, the lowest set bit wins.
  - If rd and wr are both high in the same cycle, the write is performed and the read is dropped.
  - The device index is latched at accept. Only that spi_cs_n bit goes low.
- Read:
  - Command 0x03.
  - Address = {word_address,2'b00}, truncated or zero-extended to ADDR_BYTES*8 bits, sent MSB first.
  - Then 32 bits are read. The first byte received goes to rdata[7:0], the fourth to rdata[31:24]; each byte is received MSB first.
  - rdata updates only at read completion and holds until the next read completes.
- Write:
  - Command 0x02.
  - wmask is split into maximal contiguous runs of set bits. Each run is one CS-framed transaction, issued in ascending byte order.
  - Run address = {word_address, byte index of the run's lowest byte}.
  - Run data = the run's bytes of wdata, lowest byte first.
  - Bytes outside wmask are never transmitted.
  - wdata, wmask and the address are latched at accept.
- SPI bit timing (mode 0):
  - Each bit is CLK_DIV cycles with spi_clk low, then CLK_DIV cycles with spi_clk high.
  - spi_mosi changes only while spi_clk is low.
  - spi_miso is sampled on the clk edge that raises spi_clk.
  - spi_clk is left low at the end of a transaction.
- GAP: spi_cs_n is all ones and spi_clk is low for 2*CLK_DIV cycles after every transaction.

## Timing
- Bit counts: N_read = 8 + 8*ADDR_BYTES + 32. For a write run of k bytes, N_run = 8 + 8*ADDR_BYTES + 8k.
- Busy rise: rbusy or wbusy goes high on the clk edge that samples the accepted strobe. spi_cs_n goes low on that same edge.
- Busy fall: busy deasserts on the edge that ends GAP of the last transaction. rdata is valid on that edge.
- Read busy duration = (N_read+1)*2*CLK_DIV cycles.
- Write busy duration = sum over runs of (N_run+1)*2*CLK_DIV cycles.
- Defaults (ADDR_BYTES=3, CLK_DIV=1): read busy = 130 cycles; 4-byte write busy = 130 cycles.
- Strobes arriving while busy are ignored; the master must wait for busy low.
- No combinational path from inputs to any output. All outputs are registered.

## Test plan
- Read, defaults, dev_sel=01, word_address=0x00010; SPI model returns 0x11,0x22,0x33,0x44 → MOSI shows 03 00 00 40; only spi_cs_n[0] goes low; rbusy high for 130 cycles; rdata=0x44332211 when rbusy falls.
- Write, dev_sel=10, word_address=0x3, wdata=0xDEADBEEF, wmask=1111 → only spi_cs_n[1] goes low; MOSI shows 02 00 00 0C EF BE AD DE; wbusy high for 130 cycles.
- Same write with wmask=0110 → one transaction, MOSI 02 00 00 0D BE AD; wbusy high for 98 cycles.
- Same write with wmask=1001 → two transactions, 02 00 00 0C EF then 02 00 00 0F DE, separated by a 2-cycle CS-high gap; wbusy high for 164 cycles.
- CLK_DIV=3, ADDR_BYTES=2 read of word 0x1 → MOSI shows 03 00 04; spi_clk half-period is 3 cycles; rbusy high for (57)*6=342 cycles.
- Edge cases:
  - Reset asserted at cycle 50 of a read → spi_cs_n all ones, spi_clk=0, rbusy=0 immediately; the next read completes correctly.
  - dev_sel=0 with rd → no CS activity and busy stays 0.
  - rd and wr in the same cycle → a write transaction only.
